// File: rtl/disp_frame_rx_if.sv
// Display link bundle: the three-wire frame stream from the calculator core
// plus the 7-segment drive and frame status outputs of the receiver.
// master = frame source / display consumer, slave = disp_frame_rx.
interface disp_frame_rx_if;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_ok;
    logic       frame_err;

    modport master (
        output ser_clk, ser_data, ser_en,
        input  seg, dp, an, frame_ok, frame_err
    );

    modport slave (
        input  ser_clk, ser_data, ser_en,
        output seg, dp, an, frame_ok, frame_err
    );
endinterface

// File: rtl/disp_frame_rx.sv
// disp_frame_rx: receives 40-bit display frames over an asynchronous
// three-wire link, validates length, sync byte and checksum, latches accepted
// frames and scans them onto a 4-digit multiplexed 7-segment display.
// Optional feature macro: DISP_LZ_BLANK_EN (leading-zero blanking of d3..d1).
module disp_frame_rx #(
    parameter int         SCAN_DIV  = 6000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    disp_frame_rx_if.slave link
);

    localparam int         PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [5:0] CNT_FULL  = 6'd40;
    localparam logic [5:0] CNT_SAT   = 6'd41;

    // Synchronizer stages; [1] is the synchronized value, [2] its history.
    logic [2:0]  sclk_q;
    logic [2:0]  sen_q;
    logic [1:0]  sdat_q;

    logic [39:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  dpm_q, dpm_d;
    logic [3:0]  blm_q, blm_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;

    logic        sclk_rise, en_s, en_rise, en_fall, dat_s;
    logic [7:0]  sum_w;
    logic        frame_good;
    logic [3:0]  digit_w;
    logic [3:0]  lz_w;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign en_s      = sen_q[1];
    assign en_rise   = sen_q[1] & ~sen_q[2];
    assign en_fall   = ~sen_q[1] & sen_q[2];
    assign dat_s     = sdat_q[1];

    assign sum_w      = shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    assign frame_good = (cnt_q == CNT_FULL) && (shift_q[39:32] == SYNC_BYTE)
                        && (sum_w == shift_q[7:0]);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Bring the link wires into the clk domain, keeping one extra stage for edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '0;
            sen_q  <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], link.ser_clk};
            sen_q  <= {sen_q[1:0], link.ser_en};
            sdat_q <= {sdat_q[0], link.ser_data};
        end
    end

    // Frame start clears the capture state; each enabled ser_clk rise shifts one bit in
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (en_rise) begin
            shift_d = '0;
            cnt_d   = '0;
        end
        if (sclk_rise && en_s) begin
            shift_d = {shift_d[38:0], dat_s};
            if (cnt_d != CNT_SAT) begin
                cnt_d = cnt_d + 6'd1;
            end
        end
    end

    // Frame end: accept into the display registers or flag the frame as bad
    always_comb begin
        bcd_d = bcd_q;
        dpm_d = dpm_q;
        blm_d = blm_q;
        ok_d  = 1'b0;
        err_d = 1'b0;
        if (en_fall) begin
            if (frame_good) begin
                bcd_d = shift_q[31:16];
                dpm_d = shift_q[15:12];
                blm_d = shift_q[11:8];
                ok_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Digit slot timing: advance the scanned digit every SCAN_DIV cycles
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

`ifdef DISP_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are zero
    always_comb begin
        lz_w    = 4'b0000;
        lz_w[3] = (bcd_q[15:12] == 4'd0);
        lz_w[2] = lz_w[3] && (bcd_q[11:8] == 4'd0);
        lz_w[1] = lz_w[2] && (bcd_q[7:4] == 4'd0);
    end
`else
    assign lz_w = 4'b0000;
`endif

    // Drive values for the current digit slot; registered below so they move together
    always_comb begin
        digit_w = bcd_q[{idx_q, 2'b00} +: 4];
        an_d    = ~(4'b0001 << idx_q);
        dp_d    = dpm_q[idx_q];
        if (blm_q[idx_q] || lz_w[idx_q] || (digit_w > 4'd9)) begin
            seg_d = 7'b0000000;
        end else begin
            seg_d = seg_decode(digit_w);
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            dpm_q   <= '0;
            blm_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b0111111;
            an_q    <= 4'b1110;
            dp_q    <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            dpm_q   <= dpm_d;
            blm_q   <= blm_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign link.seg       = seg_q;
    assign link.an        = an_q;
    assign link.dp        = dp_q;
    assign link.frame_ok  = ok_q;
    assign link.frame_err = err_q;

endmodule

// File: tb/tb_disp_frame_rx.sv
// Bench for disp_frame_rx: table of known frames, hand sequences for reset,
// scan timing and reset mid-frame, then random frames against a reference model.
module tb_disp_frame_rx;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         HALF = 4;   // clk cycles per ser_clk level

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    disp_frame_rx_if bus ();

    disp_frame_rx #(.SCAN_DIV(4), .SYNC_BYTE(SYNC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .link   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        bit          exp_ok;
        logic [27:0] exp_seg;   // {d3, d2, d1, d0}, 7 bits each
        logic [3:0]  exp_dp;
        string       name;
    } vec_t;

    vec_t tbl[8];

    // Reference display state
    int         m_bcd[4];
    logic [3:0] m_dpm;
    logic [3:0] m_blm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] tab[10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v < 0 || v > 9) return 7'h00;
        return tab[v];
    endfunction

    function automatic int an2idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_bcd[i] = 0;
        m_dpm = 4'h0;
        m_blm = 4'h0;
    endtask

    function automatic bit model_accept(input logic [63:0] bits, input int nbits);
        int s;
        if (nbits != 40) return 1'b0;
        if (bits[39:32] != SYNC) return 1'b0;
        s = (int'(bits[31:24]) + int'(bits[23:16]) + int'(bits[15:8])) % 256;
        return (s == int'(bits[7:0]));
    endfunction

    task automatic model_apply(input logic [63:0] bits);
        m_bcd[3] = int'(bits[31:28]);
        m_bcd[2] = int'(bits[27:24]);
        m_bcd[1] = int'(bits[23:20]);
        m_bcd[0] = int'(bits[19:16]);
        m_dpm    = bits[15:12];
        m_blm    = bits[11:8];
    endtask

    function automatic logic [6:0] model_seg(input int i);
        bit blank;
        blank = m_blm[i] || (m_bcd[i] > 9);
`ifdef DISP_LZ_BLANK_EN
        if (i > 0) begin
            bit allz;
            allz = 1'b1;
            for (int j = i; j < 4; j++) if (m_bcd[j] != 0) allz = 1'b0;
            blank = blank || allz;
        end
`endif
        return blank ? 7'h00 : seg_of(m_bcd[i]);
    endfunction

    function automatic logic [27:0] model_segs();
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[i*7 +: 7] = model_seg(i);
        return r;
    endfunction

    // Shift a frame out MSB first, then expect exactly one status pulse 3 cycles after ser_en falls
    task automatic run_frame(input logic [63:0] bits, input int nbits, input bit exp_ok,
                             input string name);
        int ok_n, err_n, first_at;
        bus.ser_en = 1'b1;
        wait_cyc(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.ser_data = bits[i];
            wait_cyc(HALF);
            bus.ser_clk = 1'b1;
            wait_cyc(HALF);
            bus.ser_clk = 1'b0;
        end
        wait_cyc(HALF);
        bus.ser_en   = 1'b0;
        bus.ser_data = 1'b0;
        ok_n = 0; err_n = 0; first_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.frame_ok)  ok_n++;
            if (bus.frame_err) err_n++;
            if ((bus.frame_ok || bus.frame_err) && first_at == 0) first_at = c;
        end
        chk({name, "_ok_pulses"}, 32'(ok_n), exp_ok ? 32'd1 : 32'd0);
        chk({name, "_err_pulses"}, 32'(err_n), exp_ok ? 32'd0 : 32'd1);
        chk({name, "_pulse_latency"}, 32'(first_at), 32'd3);
        $display("frame %s nbits=%0d bits=0x%0h ok=%0d err=%0d", name, nbits, bits, ok_n, err_n);
    endtask

    // Watch several scan rounds and compare every digit slot against the expectation
    task automatic check_display(input string name, input logic [27:0] exp_seg,
                                 input logic [3:0] exp_dp);
        logic [3:0] seen;
        int k;
        seen = 4'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            k = an2idx(bus.an);
            chk({name, "_an_onehot"}, (k >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (k >= 0) begin
                chk($sformatf("%s_seg_d%0d", name, k), 32'(bus.seg), 32'(exp_seg[k*7 +: 7]));
                chk($sformatf("%s_dp_d%0d", name, k), 32'(bus.dp), 32'(exp_dp[k]));
                seen[k] = 1'b1;
            end
        end
        chk({name, "_all_digits_scanned"}, 32'(seen), 32'hF);
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  dpm, blm;
        logic [7:0]  cs;
        logic [39:0] f40;
        logic [63:0] bits;
        int          nb, mode, run, prev_k, k, pulses;
        bit          have_change, exp_ok;

        checks = 0;
        failures = 0;
        bus.ser_clk  = 1'b0;
        bus.ser_data = 1'b0;
        bus.ser_en   = 1'b0;
        rst_n = 1'b0;
        model_reset();

        tbl[0] = '{64'hA5_1234_00_46, 40, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, "valid_1234"};
        tbl[1] = '{64'hA4_1234_00_46, 40, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, "bad_sync"};
        tbl[2] = '{64'h52_891A_00_23, 39, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, "len_39"};
        tbl[3] = '{64'h16_A5_0009_00_09, 45, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, "len_45"};
        tbl[4] = '{64'h01_A5_1234_00_46, 41, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, "len_41"};
`ifdef DISP_LZ_BLANK_EN
        tbl[5] = '{64'hA5_0009_00_09, 40, 1'b1, {7'h00, 7'h00, 7'h00, 7'h6F}, 4'h0, "valid_0009"};
`else
        tbl[5] = '{64'hA5_0009_00_09, 40, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h6F}, 4'h0, "valid_0009"};
`endif
        tbl[6] = '{64'hA5_5A37_28_B9, 40, 1'b1, {7'h00, 7'h00, 7'h4F, 7'h07}, 4'b0010, "masks_5A37"};
        tbl[7] = '{64'hA5_5A37_28_B8, 40, 1'b0, {7'h00, 7'h00, 7'h4F, 7'h07}, 4'b0010, "bad_checksum"};

        // Reset state, while held and just after release
        wait_cyc(3);
        chk("rst_an", 32'(bus.an), 32'b1110);
        chk("rst_seg", 32'(bus.seg), 32'h3F);
        chk("rst_dp", 32'(bus.dp), 32'd0);
        chk("rst_frame_ok", 32'(bus.frame_ok), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("post_rst_an", 32'(bus.an), 32'b1110);
        chk("post_rst_seg", 32'(bus.seg), 32'h3F);
        $display("reset: an=%b seg=%b dp=%b", bus.an, bus.seg, bus.dp);

        // Scan period: each anode held exactly SCAN_DIV cycles, in order 0,1,2,3,0...
        have_change = 1'b0;
        run = 1;
        prev_k = an2idx(bus.an);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            k = an2idx(bus.an);
            if (k != prev_k) begin
                chk("scan_order", 32'(k), 32'((prev_k + 1) % 4));
                if (have_change) chk("scan_hold_cycles", 32'(run), 32'd4);
                have_change = 1'b1;
                run = 1;
                prev_k = k;
            end else begin
                run++;
            end
        end
        $display("scan: last an=%b run=%0d", bus.an, run);
        check_display("reset_disp", model_segs(), m_dpm);

        // Known frames from the table
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].bits, tbl[i].nbits, tbl[i].exp_ok, tbl[i].name);
            if (model_accept(tbl[i].bits, tbl[i].nbits)) model_apply(tbl[i].bits);
            wait_cyc(2);
            check_display(tbl[i].name, tbl[i].exp_seg, tbl[i].exp_dp);
        end

        // Reset in the middle of a frame: no pulse, display back to reset state
        bus.ser_en = 1'b1;
        wait_cyc(HALF);
        for (int i = 0; i < 20; i++) begin
            bus.ser_data = 1'($urandom_range(0, 1));
            wait_cyc(HALF);
            bus.ser_clk = 1'b1;
            wait_cyc(HALF);
            bus.ser_clk = 1'b0;
        end
        rst_n = 1'b0;
        wait_cyc(1);
        chk("midrst_an", 32'(bus.an), 32'b1110);
        chk("midrst_seg", 32'(bus.seg), 32'h3F);
        chk("midrst_dp", 32'(bus.dp), 32'd0);
        bus.ser_en = 1'b0;
        bus.ser_data = 1'b0;
        wait_cyc(HALF);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.frame_ok || bus.frame_err) pulses++;
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        $display("reset mid-frame: pulses=%0d an=%b seg=%b", pulses, bus.an, bus.seg);
        model_reset();
        check_display("midrst_disp", model_segs(), m_dpm);

        // Random frames checked against the reference model
        for (int r = 0; r < 14; r++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 7) == 0) d[j*4 +: 4] = 4'($urandom_range(10, 15));
                else                           d[j*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
            dpm = 4'($urandom_range(0, 15));
            blm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cs  = d[15:8] + d[7:0] + {dpm, blm};
            f40 = {SYNC, d, dpm, blm, cs};
            mode = (r == 0) ? 0 : int'($urandom_range(0, 3));
            nb = 40;
            bits = {24'h0, f40};
            if (mode == 2) begin
                bits = bits ^ (64'd1 << $urandom_range(0, 39));
            end else if (mode == 3) begin
                nb = int'($urandom_range(36, 44));
                bits = {24'($urandom), f40};
            end
            exp_ok = model_accept(bits, nb);
            run_frame(bits, nb, exp_ok, $sformatf("rand%0d", r));
            if (exp_ok) model_apply(bits);
            wait_cyc(2);
            check_display($sformatf("rand%0d", r), model_segs(), m_dpm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_frame_rx.md
# disp_frame_rx

Display-side receiver for the calculator's serial display link. It takes the three-wire frame stream from the calculator core (serial clock, data, enable) and checks each 40-bit frame for length, sync byte and checksum. Accepted frames are latched and drive a time-multiplexed 4-digit 7-segment display. It sits directly downstream of the calculator's display serializer, on the display board, in its own clock domain.

## Interface
Parameters:
- SCAN_DIV, 6000: clk cycles per digit slot (1 ms at 6 MHz).
- SYNC_BYTE, 8'hA5: required first byte of every frame.

Ports:
- clk  in  1  system clock (6 MHz HFOSC).
- rst  in  1  asynchronous, active-low reset; all state clears on assertion.
- ser_clk  in  1  link serial clock, asynchronous to clk.
- ser_data  in  1  link data, sampled on ser_clk rising edge.
- ser_en  in  1  frame enable, high for the whole frame.
- seg  out  7  segments a..g, active-high.
- dp  out  1  decimal point of the current digit, active-high.
- an  out  4  digit anodes, active-low, one-hot low.
- frame_ok  out  1  one-cycle pulse when a frame is accepted.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Input sync:** ser_clk, ser_data and ser_en each pass through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized signals.
- **Bit capture:** on a synchronized ser_clk rising edge with synchronized ser_en high, shift ser_data into a 40-bit shift register, MSB first. The bit counter (6 bits) increments and saturates at 41, where it means overlength.
- **Frame start:** a ser_en rising edge clears the bit counter and the shift register.
- **Frame end:** a ser_en falling edge evaluates the frame.
  - Frame layout: [39:32] sync, [31:16] BCD d3..d0, [15:12] dp mask, [11:8] blank mask, [7:0] checksum.
  - The checksum is the mod-256 sum of bytes [31:24], [23:16] and [15:8].
  - Accept only if count==40, sync==SYNC_BYTE and the checksum matches. On accept, latch BCD, dp mask and blank mask into the display registers and pulse frame_ok.
  - Otherwise pulse frame_err and keep the display registers unchanged.
- **Ignored edges:** a ser_clk edge while ser_en is low is ignored. A ser_clk edge in the same cycle as the ser_en falling edge is ignored, because synchronized ser_en is already low.
- **Scan:** a prescaler counts 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→2→3→0.
  - an[i] is low only for index i.
  - Digit 0 is the units digit, d0.
  - dp = dp_mask[i].
  - If blank_mask[i] is set, or the BCD value is >9, seg = 0.
  - Otherwise seg shows the standard 0–9 decode: 0 = 7'b0111111 in g..a order, i.e. seg[0]=a.
- **Reset values:** BCD 0000, masks 0, digit index 0, prescaler 0, an=4'b1110, seg=7'b0111111 ("0"), dp=0, frame_ok=0, frame_err=0, counters 0.
- **Reset mid-frame:** the partial frame is discarded with no pulse. The display returns to the reset values.

## Timing
- Synchronizer latency is 2 cycles; the edge is detected in the 3rd cycle after the input transition.
- A bit is shifted 3 clk cycles after the ser_clk rise.
- frame_ok or frame_err asserts 3 cycles after the ser_en fall and lasts exactly 1 cycle.
- The display registers update in that same cycle.
- seg, an and dp are registered. They change 1 cycle after the prescaler wrap and always together, with no glitch between digits.
- The link must hold each ser_clk level for at least 3 clk cycles. The serializer's 301-cycle half-period satisfies this.

## Configuration
- **DISP_LZ_BLANK_EN**
  - Defined: leading zeros are blanked. d3 blanks if it is 0; d2 blanks if d3 and d2 are 0; d1 blanks if d3..d1 are 0. d0 is never blanked by this rule. Blanking ORs with the blank mask.
  - Undefined: all four digits are always shown unless masked.
  - Reset display with the macro: only d0 shows "0".

## Test plan
- **Valid frame:** frame A5_1234_00_xx, with the correct checksum 0x1234+0x00 bytes = 0x46 → frame_ok pulse. an scan shows 4,3,2,1 on digits 0..3. seg for digit 0 = 7'b1100110.
- **Bad sync:** same frame with byte 0xA4 → frame_err pulse; the display still shows the prior value.
- **Wrong length:** a 39-bit frame, then a 45-bit frame → each gives frame_err. A following valid frame 0009 is accepted; with DISP_LZ_BLANK_EN only an[0] shows "9" and seg=0 on the other digits.
- **Masks and invalid BCD:** frame with dp mask 4'b0010, blank mask 4'b1000, BCD 0x5A37 → dp only on digit 1; digit 3 blank; digit 2 (value A) blank; 7 and 3 shown.
- **Reset mid-frame:** rst low after 20 bits → no pulse; display reads 0000. A subsequent full frame is accepted normally.
- **Scan period:** with SCAN_DIV=4, an sequence is 1110,1101,1011,0111, each held exactly 4 cycles, then wraps.
